// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU/video/memory bus bundle for mem_bus_arbiter
// slave is the arbiter's view; master is the requester/memory side.
interface mem_bus_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        b_req;
  logic [31:0] b_addr;
  logic [3:0]  b_len;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_done;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, b_len, mem_rdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, b_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_addr, b_len, mem_rdata,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, b_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter between CPU single accesses and video bursts
// Grants are combinational in the arbitration cycle; read data returns one cycle later.
module mem_bus_arbiter (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC_A, BURST_B} state_t;

  state_t      state_q, state_d;
  logic        ptr_a_q, ptr_a_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        a_rvalid_q, a_rvalid_d;
  logic        b_rvalid_q, b_rvalid_d;
  logic        b_done_q, b_done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_a_q    <= 1'b1;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_a_q    <= ptr_a_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      b_done_q   <= b_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_a_d       = ptr_a_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    b_done_d      = 1'b0;
    bus.a_gnt     = 1'b0;
    bus.b_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    // Outputs stay quiet while reset is held, even with requests pending.
    if (!reset) begin
      case (state_q)
        BURST_B: begin
          bus.mem_en = 1'b1;
          bus.mem_addr = addr_q;
          addr_d     = addr_q + 32'd4;
          cnt_d      = cnt_q - 4'd1;
          b_rvalid_d = 1'b1;
          if (cnt_q == 4'd1) begin
            state_d  = IDLE;
            ptr_a_d  = 1'b1;
            b_done_d = 1'b1;
          end
        end
        default: begin
          // IDLE and the cycle after a CPU access both arbitrate.
          state_d = IDLE;
          if (bus.a_req && (!bus.b_req || ptr_a_q)) begin
            bus.a_gnt     = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.a_we;
            bus.mem_addr  = bus.a_addr;
            bus.mem_wdata = bus.a_wdata;
            a_rvalid_d    = !bus.a_we;
            ptr_a_d       = 1'b0;
            state_d       = ACC_A;
          end else if (bus.b_req) begin
            bus.b_gnt    = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.b_addr;
            addr_d       = bus.b_addr + 32'd4;
            cnt_d        = bus.b_len;
            b_rvalid_d   = 1'b1;
            if (bus.b_len == 4'd0) begin
              b_done_d = 1'b1;
              ptr_a_d  = 1'b1;
            end else begin
              state_d = BURST_B;
            end
          end
        end
      endcase
    end
  end

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_rdata  = a_rvalid_q ? bus.mem_rdata : 32'd0;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_rdata  = b_rvalid_q ? bus.mem_rdata : 32'd0;
  assign bus.b_done   = b_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized bench for mem_bus_arbiter
// A transaction-level model (priority flag plus a queue of pending burst addresses) predicts every cycle.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous memory: read data one cycle after the strobe.
  always @(posedge clk)
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem_val(bus.mem_addr) : 32'h0;

  // Reference model state
  bit          m_ptr_a = 1'b1;
  logic [31:0] bq[$];
  bit          pa = 0, pb = 0, pd = 0;
  logic [31:0] pa_data = 0, pb_data = 0;

  always @(negedge clk) begin
    bit          e_agnt, e_bgnt, e_en, e_we, nb_rv, nb_done, na;
    logic [31:0] e_addr, e_wd;
    if (reset) begin
      check("rst_flags", 32'({bus.a_gnt, bus.b_gnt, bus.mem_en, bus.mem_we,
                              bus.a_rvalid, bus.b_rvalid, bus.b_done}), 32'd0);
      check("rst_bus", bus.mem_addr | bus.mem_wdata | bus.a_rdata | bus.b_rdata, 32'd0);
      m_ptr_a = 1'b1;
      bq.delete();
      pa = 0; pb = 0; pd = 0;
    end else begin
      check("a_rvalid", 32'(bus.a_rvalid), 32'(pa));
      if (pa) check("a_rdata", bus.a_rdata, pa_data);
      check("b_rvalid", 32'(bus.b_rvalid), 32'(pb));
      if (pb) check("b_rdata", bus.b_rdata, pb_data);
      check("b_done", 32'(bus.b_done), 32'(pd));
      e_agnt = 0; e_bgnt = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
      nb_rv = 0; nb_done = 0; na = 0;
      if (bq.size() > 0) begin
        e_en = 1; e_addr = bq.pop_front(); nb_rv = 1;
        nb_done = (bq.size() == 0);
        if (nb_done) m_ptr_a = 1'b1;
      end else if (bus.a_req && (!bus.b_req || m_ptr_a)) begin
        e_agnt = 1; e_en = 1; e_we = bus.a_we; e_addr = bus.a_addr; e_wd = bus.a_wdata;
        na = !bus.a_we;
        m_ptr_a = 1'b0;
      end else if (bus.b_req) begin
        e_bgnt = 1; e_en = 1; e_addr = bus.b_addr; nb_rv = 1;
        for (int k = 1; k <= int'(bus.b_len); k++) bq.push_back(bus.b_addr + 32'(4 * k));
        nb_done = (bus.b_len == 4'd0);
        if (nb_done) m_ptr_a = 1'b1;
      end
      check("a_gnt", 32'(bus.a_gnt), 32'(e_agnt));
      check("b_gnt", 32'(bus.b_gnt), 32'(e_bgnt));
      check("mem_en", 32'(bus.mem_en), 32'(e_en));
      check("mem_we", 32'(bus.mem_we), 32'(e_we));
      check("mem_addr", bus.mem_addr, e_addr);
      if (e_agnt || !e_en) check("mem_wdata", bus.mem_wdata, e_wd);
      pa = na; pa_data = mem_val(e_addr);
      pb = nb_rv; pb_data = mem_val(e_addr); pd = nb_done;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic ga, gb;
  int   n;

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_addr = 0; bus.b_len = 0;
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;

    // CPU read of 0x100
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h100;
    @(negedge clk);
    check("d1_a_gnt", 32'(bus.a_gnt), 32'd1);
    check("d1_b_gnt", 32'(bus.b_gnt), 32'd0);
    check("d1_mem_addr", bus.mem_addr, 32'h100);
    cyc(); bus.a_req = 0;
    @(negedge clk);
    check("d1_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    check("d1_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    check("d1_b_rvalid", 32'(bus.b_rvalid), 32'd0);

    // 4-word burst at 0x400
    cyc(); bus.b_req = 1; bus.b_addr = 32'h400; bus.b_len = 4'd3;
    @(negedge clk);
    check("d2_b_gnt", 32'(bus.b_gnt), 32'd1);
    check("d2_addr0", bus.mem_addr, 32'h400);
    for (int k = 1; k <= 4; k++) begin
      cyc(); bus.b_req = 0;
      @(negedge clk);
      if (k <= 3) check("d2_addr", bus.mem_addr, 32'h400 + 32'(4 * k));
      check("d2_b_rvalid", 32'(bus.b_rvalid), 32'd1);
      check("d2_b_done", 32'(bus.b_done), 32'(k == 4));
    end

    // Contention right after reset, then again after the burst
    cyc(); reset = 1;
    cyc(); reset = 0;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h200; bus.a_wdata = 32'h12345678;
    bus.b_req = 1; bus.b_addr = 32'h1000; bus.b_len = 4'd1;
    @(negedge clk);
    check("d3_a_first", 32'(bus.a_gnt), 32'd1);
    check("d3_b_held", 32'(bus.b_gnt), 32'd0);
    cyc(); bus.a_req = 0;
    @(negedge clk);
    check("d3_b_next", 32'(bus.b_gnt), 32'd1);
    cyc(); bus.b_req = 0;
    @(negedge clk);
    cyc(); bus.a_req = 1; bus.b_req = 1;
    @(negedge clk);
    check("d3_a_again", 32'(bus.a_gnt), 32'd1);
    check("d3_b_again", 32'(bus.b_gnt), 32'd0);
    cyc(); bus.a_req = 0; bus.b_req = 0;

    // CPU held off by a 16-word burst
    cyc(); bus.b_req = 1; bus.b_addr = 32'h2000; bus.b_len = 4'd15;
    @(negedge clk);
    check("d4_b_gnt", 32'(bus.b_gnt), 32'd1);
    cyc(); bus.b_req = 0; bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h300;
    n = 0;
    @(negedge clk);
    while (!bus.a_gnt && n < 20) begin
      cyc(); n++;
      @(negedge clk);
    end
    check("d4_wait", 32'(n), 32'd15);
    check("d4_a_gnt", 32'(bus.a_gnt), 32'd1);
    cyc(); bus.a_req = 0;

    // Address wrap
    cyc(); bus.b_req = 1; bus.b_addr = 32'hFFFFFFF8; bus.b_len = 4'd2;
    @(negedge clk);
    check("d5_addr0", bus.mem_addr, 32'hFFFFFFF8);
    cyc(); bus.b_req = 0;
    @(negedge clk);
    check("d5_addr1", bus.mem_addr, 32'hFFFFFFFC);
    cyc();
    @(negedge clk);
    check("d5_addr2", bus.mem_addr, 32'h00000000);
    check("d5_en2", 32'(bus.mem_en), 32'd1);

    // Reset during an 8-word burst after two reads
    cyc(); bus.b_req = 1; bus.b_addr = 32'h800; bus.b_len = 4'd7;
    @(negedge clk);
    cyc(); bus.b_req = 0;
    @(negedge clk);
    cyc(); reset = 1;
    #1;
    check("d6_mem_en", 32'(bus.mem_en), 32'd0);
    check("d6_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    check("d6_mem_addr", bus.mem_addr, 32'd0);
    cyc();
    cyc(); reset = 0; bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h104;
    @(negedge clk);
    check("d6_a_gnt", 32'(bus.a_gnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.a_req = 0;
      @(negedge clk);
      check("d6_no_done", 32'(bus.b_done), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ga = bus.a_gnt; gb = bus.b_gnt;
      cyc();
      if (reset) reset = 0;
      else if ($urandom_range(0, 299) == 0) reset = 1;
      if (!bus.a_req || ga) begin
        bus.a_req   = ($urandom_range(0, 2) == 0);
        bus.a_we    = 1'($urandom_range(0, 1));
        bus.a_addr  = $urandom & 32'hFFFFFFFC;
        bus.a_wdata = $urandom;
      end
      if (!bus.b_req || gb) begin
        bus.b_req  = ($urandom_range(0, 3) == 0);
        bus.b_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFC0 | ($urandom & 32'h3C))
                                                 : ($urandom & 32'hFFFFFFFC);
        bus.b_len  = 4'($urandom_range(0, 15));
      end
    end

    bus.a_req = 0; bus.b_req = 0; reset = 0;
    repeat (20) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
